// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing add sequencer:
// FSM state encoding, stream length and the low-discrepancy index reversal.
package sc_pkg;

  localparam int MAX_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int stream_len(input int width);
    return 1 << width;
  endfunction

  // Reverses the low 'width' bits of value; higher bits of the result are zero.
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] value,
                                                       input int width);
    logic [MAX_WIDTH-1:0] src;
    logic [MAX_WIDTH-1:0] rev;
    src = value;
    rev = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      rev = {rev[MAX_WIDTH-2:0], src[0]};
      src = src >> 1;
    end
    return rev >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/sc_add_sequencer_if.sv
// Host-side bundle of the SC add sequencer: operand/result handshakes plus
// the per-cycle stream observation taps.
interface sc_add_sequencer_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   y_count;
  logic             bit_valid;
  logic             sa;
  logic             sb;
  logic             sel;
  logic             y_bit;

  modport master (
    output in_valid, a_val, b_val, abort, out_ready,
    input  in_ready, out_valid, y_count, bit_valid, sa, sb, sel, y_bit
  );

  modport slave (
    input  in_valid, a_val, b_val, abort, out_ready,
    output in_ready, out_valid, y_count, bit_valid, sa, sb, sel, y_bit
  );

endinterface

// File: rtl/sc_sng.sv
// Comparator stochastic number generator: emits 1 when the shared random
// index falls below the operand level, giving probability level/N.
module sc_sng #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] index,
  input  logic [WIDTH-1:0] level,
  output logic             stream
);

  assign stream = (index < level);

endmodule

// File: rtl/sc_add_sequencer.sv
// Sequences one SC scaled addition y ~ (a+b)/2 over a full 2^WIDTH-cycle
// period and returns the ones-count of the selected stream.
module sc_add_sequencer
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  sc_add_sequencer_if.slave host
);

  localparam logic [WIDTH-1:0] C_LAST = WIDTH'(stream_len(WIDTH) - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH:0]   y_count_reg;

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] level [2];
  logic [1:0]       stream;
  logic             sel_raw;
  logic             y_raw;
  logic             running;
  logic             accept;
  logic             last;

  // Both operands share one index so the A and B streams are correlated.
  assign r        = WIDTH'(bit_reverse(MAX_WIDTH'(c_reg), WIDTH));
  assign level[0] = a_reg;
  assign level[1] = b_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sng
    sc_sng #(.WIDTH(WIDTH)) u_sng (
      .index  (r),
      .level  (level[gi]),
      .stream (stream[gi])
    );
  end

  assign sel_raw = c_reg[WIDTH-1];
  assign y_raw   = sel_raw ? stream[0] : stream[1];
  assign running = (state_reg == RUN);
  assign accept  = (state_reg == IDLE) && host.in_valid;
  assign last    = running && (c_reg == C_LAST);

  always_comb begin
    state_next     = state_reg;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    host.bit_valid = 1'b0;
    unique case (state_reg)
      IDLE: begin
        host.in_ready = 1'b1;
        if (host.in_valid) state_next = RUN;
      end
      RUN: begin
        host.bit_valid = 1'b1;
        if (host.abort)   state_next = IDLE;
        else if (last)    state_next = DONE;
      end
      DONE: begin
        host.out_valid = 1'b1;
        if (host.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      c_reg       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      y_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg   <= host.a_val;
        b_reg   <= host.b_val;
        c_reg   <= '0;
        acc_reg <= '0;
      end else if (running) begin
        c_reg   <= c_reg + WIDTH'(1);
        acc_reg <= acc_reg + (WIDTH+1)'(y_raw);
        // The final bit is folded in here, so the result needs no extra cycle.
        if (last && !host.abort) y_count_reg <= acc_reg + (WIDTH+1)'(y_raw);
      end
    end
  end

  assign host.y_count = y_count_reg;
  assign host.sa      = running & stream[0];
  assign host.sb      = running & stream[1];
  assign host.sel     = running & sel_raw;
  assign host.y_bit   = running & y_raw;

endmodule

// File: tb/tb_sc_add_sequencer.sv
// Directed-vector bench for sc_add_sequencer: table-driven operand pairs,
// backpressure, abort, asynchronous reset and a short random sweep.
module tb_sc_add_sequencer;

  localparam int WIDTH = 8;
  localparam int N     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_add_sequencer_if #(.WIDTH(WIDTH)) host_if ();

  sc_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int a;
    int b;
    int y;
    int stall;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  task automatic start_op(input int a, input int b);
    int w;
    w = 0;
    while (!host_if.in_ready && w < 2 * N) begin
      tick();
      w++;
    end
    check("in_ready_before_accept", int'(host_if.in_ready), 1);
    host_if.a_val    = 8'(a);
    host_if.b_val    = 8'(b);
    host_if.in_valid = 1'b1;
    tick();
    host_if.in_valid = 1'b0;
    check("in_ready_after_accept", int'(host_if.in_ready), 0);
  endtask

  // Called right after the accept edge; walks the N stream cycles and the result handshake.
  task automatic finish_op(input int a, input int b, input int exp_y, input int stall);
    int cyc;
    int errs;
    int hold_errs;
    logic [7:0] c;
    logic [7:0] r;
    logic esa, esb, esel, ey;
    cyc  = 0;
    errs = 0;
    while (host_if.bit_valid && cyc < N + 4) begin
      c    = 8'(cyc);
      r    = rev8(c);
      esa  = (r < 8'(a));
      esb  = (r < 8'(b));
      esel = (cyc >= N / 2);
      ey   = esel ? esa : esb;
      if ({host_if.sa, host_if.sb, host_if.sel, host_if.y_bit} !== {esa, esb, esel, ey}) errs++;
      if (host_if.out_valid !== 1'b0) errs++;
      tick();
      cyc++;
    end
    check("bit_valid_cycles", cyc, N);
    check("stream_bit_errors", errs, 0);
    check("out_valid_after_run", int'(host_if.out_valid), 1);
    check("y_count", int'(host_if.y_count), exp_y);
    hold_errs = 0;
    for (int s = 0; s < stall; s++) begin
      if (host_if.out_valid !== 1'b1 || int'(host_if.y_count) != exp_y ||
          host_if.in_ready !== 1'b0 || host_if.bit_valid !== 1'b0) hold_errs++;
      tick();
    end
    if (stall > 0) check("backpressure_hold", hold_errs, 0);
    host_if.out_ready = 1'b1;
    tick();
    host_if.out_ready = 1'b0;
    check("out_valid_dropped", int'(host_if.out_valid), 0);
    check("in_ready_returned", int'(host_if.in_ready), 1);
    check("y_count_kept", int'(host_if.y_count), exp_y);
    $display("op a=%0d b=%0d stall=%0d -> y_count=%0d (expected %0d)",
             a, b, stall, host_if.y_count, exp_y);
  endtask

  task automatic abort_op(input int a, input int b, input int at_cycle, input int prev_y);
    int late_valid;
    start_op(a, b);
    for (int j = 0; j < at_cycle; j++) tick();
    host_if.abort = 1'b1;
    tick();
    host_if.abort = 1'b0;
    check("abort_in_ready", int'(host_if.in_ready), 1);
    check("abort_bit_valid", int'(host_if.bit_valid), 0);
    check("abort_out_valid", int'(host_if.out_valid), 0);
    check("abort_y_count_kept", int'(host_if.y_count), prev_y);
    late_valid = 0;
    for (int j = 0; j < 5; j++) begin
      if (host_if.out_valid !== 1'b0 || host_if.bit_valid !== 1'b0) late_valid++;
      tick();
    end
    check("abort_stays_idle", late_valid, 0);
    $display("abort a=%0d b=%0d at RUN cycle %0d -> y_count=%0d", a, b, at_cycle, host_if.y_count);
  endtask

  initial begin
    int a;
    int b;
    int st;

    vecs[0] = '{a: 0,   b: 0,   y: 0,   stall: 0};
    vecs[1] = '{a: 255, b: 255, y: 255, stall: 0};
    vecs[2] = '{a: 200, b: 100, y: 150, stall: 20};
    vecs[3] = '{a: 255, b: 0,   y: 127, stall: 1};
    vecs[4] = '{a: 0,   b: 1,   y: 1,   stall: 0};
    vecs[5] = '{a: 1,   b: 0,   y: 0,   stall: 2};
    vecs[6] = '{a: 3,   b: 3,   y: 3,   stall: 0};
    vecs[7] = '{a: 128, b: 127, y: 128, stall: 0};
    vecs[8] = '{a: 254, b: 2,   y: 128, stall: 3};
    vecs[9] = '{a: 17,  b: 33,  y: 25,  stall: 0};

    host_if.in_valid  = 1'b0;
    host_if.a_val     = '0;
    host_if.b_val     = '0;
    host_if.abort     = 1'b0;
    host_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(host_if.in_ready), 1);
    check("reset_out_valid", int'(host_if.out_valid), 0);
    check("reset_y_count", int'(host_if.y_count), 0);
    check("reset_taps", int'({host_if.bit_valid, host_if.sa, host_if.sb, host_if.sel, host_if.y_bit}), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      finish_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].stall);
    end

    // Previous result is 25 from the last table entry.
    abort_op(90, 60, 100, 25);
    abort_op(200, 200, N - 1, 25);

    // Abort outside RUN must not disturb an idle block.
    host_if.abort = 1'b1;
    tick();
    host_if.abort = 1'b0;
    check("idle_abort_ignored", int'(host_if.in_ready), 1);

    // Asynchronous reset between edges while running.
    start_op(30, 40);
    for (int j = 0; j < 50; j++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", int'(host_if.in_ready), 1);
    check("midrun_rst_out_valid", int'(host_if.out_valid), 0);
    check("midrun_rst_y_count", int'(host_if.y_count), 0);
    check("midrun_rst_taps", int'({host_if.bit_valid, host_if.sa, host_if.sb, host_if.sel, host_if.y_bit}), 0);
    $display("reset mid-run -> in_ready=%0d bit_valid=%0d y_count=%0d",
             host_if.in_ready, host_if.bit_valid, host_if.y_count);
    #2;
    rst_n = 1'b1;
    tick();
    start_op(64, 64);
    finish_op(64, 64, 64, 0);

    for (int i = 0; i < 60; i++) begin
      a  = int'($urandom_range(0, N - 1));
      b  = int'($urandom_range(0, N - 1));
      st = int'($urandom_range(0, 3));
      start_op(a, b);
      finish_op(a, b, a / 2 + (b + 1) / 2, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_add_sequencer.md
# sc_add_sequencer

Controller that sequences one stochastic-computing (SC) scaled addition, y ≈ (a+b)/2. It accepts two unsigned binary operands over a valid/ready handshake and generates their unipolar bit-streams from a shared deterministic low-discrepancy source. Each cycle it drives the 2:1 SC select, counts the ones in the selected stream over one full period, and returns the binary count over a second handshake. It sits between the binary host interface and the SC adder datapath, and exposes the per-cycle streams for observation.

## Interface
- WIDTH, 8: operand precision; stream length N = 2^WIDTH cycles; legal range 2..12.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair (high only in IDLE).
- a_val  in  WIDTH  operand A, unsigned; probability a_val/N.
- b_val  in  WIDTH  operand B, unsigned; probability b_val/N.
- abort  in  1  cancels a run in progress.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y_count  out  WIDTH+1  number of ones in the output stream, range 0..N.
- bit_valid  out  1  high during each RUN cycle.
- sa, sb, sel, y_bit  out  1 each  current A stream bit, B stream bit, select bit, output bit.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, y_count=0, bit_valid=0, sa=sb=sel=y_bit=0. Internal counter c=0, accumulator=0.
- IDLE: in_ready=1. On in_valid&&in_ready, register a_val/b_val, clear c and the accumulator, and go to RUN.
- RUN, per cycle with counter c (WIDTH bits, 0..N-1) and r = bit-reverse(c):
  - sa = (r < a_reg).
  - sb = (r < b_reg).
  - sel = c[WIDTH-1].
  - y_bit = sel ? sa : sb.
  - The accumulator adds y_bit, then c increments.
- RUN ends after exactly N cycles (c = N-1 is the last cycle). Go to DONE; y_count takes the final accumulator value (including the last bit); out_valid=1.
- Resulting exact count: y_count = floor(a/2) + ceil(b/2).
- DONE: hold y_count and out_valid until out_ready. On out_valid&&out_ready, go to IDLE, drop out_valid, and keep y_count unchanged until the next result.
- abort:
  - In RUN: go to IDLE next edge, no result, out_valid stays 0, y_count keeps its prior value.
  - In IDLE/DONE: ignored.
  - abort and the last RUN cycle coincide: abort wins, no result.
- In RUN and DONE, in_valid is ignored (in_ready=0). There is no operand queueing.
- Outside RUN: sa, sb, sel, y_bit and bit_valid are forced to 0.
- Arithmetic widths:
  - Accumulator is WIDTH+1 bits and cannot overflow (max N).
  - Comparisons are unsigned WIDTH-bit.
  - c wraps N-1→0 only via the state exit.

## Timing
- Accept edge T (in_valid&&in_ready sampled high). bit_valid is high for cycles T+1..T+N. out_valid is high from T+N+1 (registered after the last bit).
- Accept-to-result latency: N+1 cycles. Minimum throughput: one operation per N+2 cycles (accept, N RUN cycles, DONE with out_ready already high).
- in_ready falls the cycle after accept. It returns the cycle after the result handshake or the abort edge.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- rst_n asserted mid-run: all state and outputs take reset values immediately (asynchronous). The partial result is discarded.

## Structure
- Shared package sc_pkg:
  - state enum {IDLE, RUN, DONE}.
  - bit_reverse function (parameterized by WIDTH).
  - Stream-length constant derivation N = 1<<WIDTH.
- Sub-module sc_sng (comparator stream generator: random-source index r and operand in, stream bit out), instantiated twice for A and B. The counter, FSM, select mux and accumulator stay in sc_add_sequencer.

## Test plan
- WIDTH=8, a=0, b=0 → y_count=0 at T+257, out_valid=1; bit_valid high for exactly 256 cycles.
- a=255, b=255 → y_count=255. Separately: a=200, b=100 → y_count=150; a=255, b=0 → y_count=127; a=0, b=1 → y_count=1.
- Backpressure: out_ready held low for 20 cycles after the result. y_count and out_valid stay stable and in_ready stays 0. A pulse of out_ready returns in_ready=1 the next cycle, and a new operand is accepted.
- abort at RUN cycle 100 → state returns to IDLE next edge, no out_valid, y_count keeps its previous result. abort coinciding with the last RUN cycle → no result.
- rst_n pulsed low mid-RUN (asynchronous, between edges) → all outputs at reset values immediately. The next operation (a=64, b=64 → 64) completes correctly.
- Random regression over 1000 operand pairs with random out_ready stalls → every y_count equals floor(a/2)+ceil(b/2). y_bit matches a sel?sa:sb reference model each cycle.
